// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph constants,
// bit order of the segment bus, and the nibble-to-glyph decode function.
package seg7_pkg;

  // Segment bus order: {dp,g,f,e,d,c,b,a}
  localparam int BIT_A  = 0;
  localparam int BIT_G  = 6;
  localparam int BIT_DP = 7;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Letters only appear in hex mode; otherwise they go dark.
  function automatic logic [6:0] seg7_decode_fn(
    input logic [3:0] nib,
    input logic       hex
  );
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = hex ? SEG_A : SEG_BLANK;
      4'hB: s = hex ? SEG_B : SEG_BLANK;
      4'hC: s = hex ? SEG_C : SEG_BLANK;
      4'hD: s = hex ? SEG_D : SEG_BLANK;
      4'hE: s = hex ? SEG_E : SEG_BLANK;
      4'hF: s = hex ? SEG_F : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder for one digit.
// Ports: i_nibble, i_hex_mode, i_blank in; o_seg = {g..a}, 1 = lit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK
                         : seg7_decode_fn(i_nibble, i_hex_mode);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with tear-free updates.
// Ports: clk, rst (async high); value/dp_in/load capture a new frame
// value; hex_mode/blank_lz are live display modes; seg_out {dp,g..a},
// digit_en one-hot select, frame_done pulses at each frame wrap.
// Optional: SEG7_GHOST_BLANK_EN turns digit_en off for the first GAP
// clocks of every slot.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 0,
  parameter int GAP        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Counter must hold both the last slot count and GAP.
  localparam int CNT_MAX =
    (CLK_DIV > GAP) ? CLK_DIV - 1 : GAP;
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF =
    (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]        r_count;
  logic [IDX_W-1:0]        r_index;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_lz_sel;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_seen;
  logic [6:0]              w_seg7;
  logic [7:0]              w_seg8;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_gap;

  assign w_tick = (r_count == LAST_CNT);
  assign w_wrap = w_tick && (r_index == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_index <= '0;
    end else begin
      r_count <= w_tick ? '0 : r_count + CNT_W'(1);
      if (w_wrap)
        r_index <= '0;
      else if (w_tick)
        r_index <= r_index + IDX_W'(1);
    end
  end

  // A load coinciding with the wrap bypasses pending straight into
  // active so the new value is not delayed a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
      end
      if (w_wrap) begin
        r_act_val <= load ? value : r_pend_val;
        r_act_dp  <= load ? dp_in : r_pend_dp;
      end
      frame_done <= w_wrap;
    end
  end

  // Digit i is a leading zero when it and every digit above are zero.
  always_comb begin
    w_lz   = '0;
    w_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_seen = w_seen | (|r_act_val[4*i +: 4]);
      w_lz[i] = ~w_seen;
    end
  end

  always_comb begin
    w_nib    = '0;
    w_dp     = 1'b0;
    w_lz_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_nib    = r_act_val[4*i +: 4];
        w_dp     = r_act_dp[i];
        w_lz_sel = w_lz[i];
      end
    end
  end

  seg7_decode u_dec (
    .i_nibble   (w_nib),
    .i_hex_mode (hex_mode),
    .i_blank    (blank_lz & w_lz_sel),
    .o_seg      (w_seg7)
  );

  always_comb begin
    w_seg8                = '0;
    w_seg8[BIT_G:BIT_A]   = w_seg7;
    w_seg8[BIT_DP]        = w_dp;
  end

  assign w_onehot = NUM_DIGITS'(1) << r_index;

`ifdef SEG7_GHOST_BLANK_EN
  assign w_gap = (r_count < CNT_W'(GAP));
`else
  assign w_gap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out  <= SEG_OFF;
      digit_en <= EN_OFF;
    end else begin
      seg_out  <= w_seg8 ^ SEG_OFF;
      digit_en <= (w_gap ? '0 : w_onehot) ^ EN_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised self-checking bench for seg7_scan_mux: two instances
// (active-high CLK_DIV=4, active-low CLK_DIV=8) against a cycle model.
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;

  logic [7:0]  seg0, seg1;
  logic [3:0]  en0, en1;
  logic        fd0, fd1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .GAP(1)
  ) dut0 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .load(load), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg_out(seg0), .digit_en(en0), .frame_done(fd0)
  );

  seg7_scan_mux #(
    .NUM_DIGITS(4), .CLK_DIV(8), .ACTIVE_LOW(1), .GAP(2)
  ) dut1 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .load(load), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .seg_out(seg1), .digit_en(en1), .frame_done(fd1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          mk   [2];
  logic [15:0] m_pv [2];
  logic [15:0] m_av [2];
  logic [3:0]  m_pd [2];
  logic [3:0]  m_ad [2];
  logic [7:0]  e_seg[2];
  logic [3:0]  e_en [2];
  logic        e_fd [2];

`ifdef SEG7_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  function automatic logic [7:0] ref_seg(
    input logic [15:0] v, input logic [3:0] d,
    input int idx, input logic hx, input logic bz);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [6:0]  s;
    upper = v >> (4 * idx);
    nib   = upper[3:0];
    s     = glyph[nib];
    if (nib > 4'd9 && !hx) s = 7'h00;
    if (bz && idx != 0 && upper == 16'h0) s = 7'h00;
    return {d[idx], s};
  endfunction

  initial begin
    int cd, gp, c, idx, fr;
    bit wrap;
    forever begin
      @(posedge clk or posedge rst);
      for (int u = 0; u < 2; u++) begin
        cd = (u == 0) ? 4 : 8;
        gp = (u == 0) ? 1 : 2;
        fr = cd * 4;
        if (rst) begin
          mk[u] = 0; m_pv[u] = '0; m_av[u] = '0;
          m_pd[u] = '0; m_ad[u] = '0; e_fd[u] = 1'b0;
          e_seg[u] = (u == 1) ? 8'hFF : 8'h00;
          e_en[u]  = (u == 1) ? 4'hF : 4'h0;
        end else begin
          c    = mk[u] % cd;
          idx  = (mk[u] / cd) % 4;
          wrap = (mk[u] % fr) == fr - 1;
          e_seg[u] = ref_seg(m_av[u], m_ad[u], idx, hex_mode, blank_lz);
          e_en[u]  = (GHOST && c < gp) ? 4'h0 : 4'(1 << idx);
          if (u == 1) begin
            e_seg[u] = ~e_seg[u];
            e_en[u]  = ~e_en[u];
          end
          e_fd[u] = wrap;
          if (wrap) begin
            m_av[u] = load ? value : m_pv[u];
            m_ad[u] = load ? dp_in : m_pd[u];
          end
          if (load) begin
            m_pv[u] = value;
            m_pd[u] = dp_in;
          end
          mk[u]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("seg0", seg0, e_seg[0]);
      check("en0",  en0,  e_en[0]);
      check("fd0",  fd0,  e_fd[0]);
      check("seg1", seg1, e_seg[1]);
      check("en1",  en1,  e_en[1]);
      check("fd1",  fd1,  e_fd[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int g;
    g = 0;
    while ((mk[0] % 16) != ph && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("phase", mk[0] % 16, ph);
  endtask

  initial begin
    int n_fd;
    n_fd = 0;
    repeat (3) @(negedge clk);
    check("rst_seg0", seg0, 8'h00);
    check("rst_en0",  en0,  4'h0);
    check("rst_fd0",  fd0,  1'b0);
    check("rst_seg1", seg1, 8'hFF);
    check("rst_en1",  en1,  4'hF);
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("rel_en0",  en0,  GHOST ? 4'h0 : 4'h1);
        check("rel_seg0", seg0, 8'h3F);
      end
      if (fd0) begin
        n_fd = n;
        break;
      end
    end
    check("fd_first", n_fd, 16);

    do_load(16'h1234, 4'h0);
    repeat (40) @(negedge clk);

    hex_mode = 1'b1;
    do_load(16'h00AF, 4'h0);
    repeat (36) @(negedge clk);
    hex_mode = 1'b0;
    repeat (32) @(negedge clk);
    hex_mode = 1'b1;
    blank_lz = 1'b1;
    repeat (32) @(negedge clk);

    do_load(16'h0050, 4'b0100);
    repeat (36) @(negedge clk);

    blank_lz = 1'b0;
    wait_phase(5);
    do_load(16'h9999, 4'h0);
    repeat (24) @(negedge clk);
    wait_phase(15);
    do_load(16'h7070, 4'b1010);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) hex_mode = 1'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom);
      value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp_in = 4'($urandom);
      load  = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    load = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_seg1", seg1, 8'hFF);
    check("async_en1",  en1,  4'hF);
    check("async_seg0", seg0, 8'h00);
    check("async_en0",  en0,  4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
